// File: rtl/stage8wb_if.sv
// rtl/stage8wb_if.sv - result, read-port and claim signals between the pipe and the write-back stage
interface stage8wb_if #(
  parameter int DATA_W = 24,
  parameter int AW     = 4
);
  logic              enable;
  logic [11:0]       pc_in;
  logic              we_in;
  logic [AW-1:0]     wr_addr_in;
  logic [DATA_W-1:0] wr_data_in;
  logic [AW-1:0]     rd_addr_a;
  logic [AW-1:0]     rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_busy_a;
  logic              rd_busy_b;
  logic              claim;
  logic [AW-1:0]     claim_addr;
  logic              claim_ready;
  logic [11:0]       pc_out;
  logic              enable_out;

  modport master (
    output enable, pc_in, we_in, wr_addr_in, wr_data_in,
    output rd_addr_a, rd_addr_b, claim, claim_addr,
    input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, claim_ready,
    input  pc_out, enable_out
  );

  modport slave (
    input  enable, pc_in, we_in, wr_addr_in, wr_data_in,
    input  rd_addr_a, rd_addr_b, claim, claim_addr,
    output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, claim_ready,
    output pc_out, enable_out
  );
endinterface

// File: rtl/stage8wb.sv
// rtl/stage8wb.sv - write-back stage owning the register file, result bypass and pending scoreboard
module stage8wb #(
  parameter int DATA_W = 24,
  parameter int NREGS  = 16
) (
  input  logic        clk,
  input  logic        rst,
  stage8wb_if.slave   bus
);
  localparam int AW = $clog2(NREGS);

  logic [DATA_W-1:0] regs [NREGS];
  logic [1:0]        cnt  [NREGS];
  logic [1:0]        cnt_nxt [NREGS];

  logic              pend_v;
  logic              pend_we;
  logic [11:0]       pend_pc;
  logic [AW-1:0]     pend_addr;
  logic [DATA_W-1:0] pend_data;

  logic commit_wr;
  logic claim_acc;
  logic bypass_a;
  logic bypass_b;

  assign commit_wr = pend_v && pend_we && (pend_addr != '0);

  always_comb begin
    bus.claim_ready = (bus.claim_addr == '0) || (cnt[bus.claim_addr] != 2'd3);
    claim_acc       = bus.claim && (bus.claim_addr != '0) && bus.claim_ready;
  end

  // A bypass hit with count 1 means the only outstanding producer is the held result.
  always_comb begin
    bypass_a = pend_v && pend_we && (pend_addr == bus.rd_addr_a);
    bypass_b = pend_v && pend_we && (pend_addr == bus.rd_addr_b);

    if (bus.rd_addr_a == '0)  bus.rd_data_a = '0;
    else if (bypass_a)        bus.rd_data_a = pend_data;
    else                      bus.rd_data_a = regs[bus.rd_addr_a];

    if (bus.rd_addr_b == '0)  bus.rd_data_b = '0;
    else if (bypass_b)        bus.rd_data_b = pend_data;
    else                      bus.rd_data_b = regs[bus.rd_addr_b];

    bus.rd_busy_a = (bus.rd_addr_a != '0) && (cnt[bus.rd_addr_a] != 2'd0) &&
                    !(bypass_a && (cnt[bus.rd_addr_a] == 2'd1));
    bus.rd_busy_b = (bus.rd_addr_b != '0) && (cnt[bus.rd_addr_b] != 2'd0) &&
                    !(bypass_b && (cnt[bus.rd_addr_b] == 2'd1));
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      cnt_nxt[i] = cnt[i];
      if (claim_acc && (bus.claim_addr == AW'(i)) &&
          !(commit_wr && (pend_addr == AW'(i)))) begin
        cnt_nxt[i] = cnt[i] + 2'd1;
      end else if (commit_wr && (pend_addr == AW'(i)) &&
                   !(claim_acc && (bus.claim_addr == AW'(i))) &&
                   (cnt[i] != 2'd0)) begin
        cnt_nxt[i] = cnt[i] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
        cnt[i]  <= 2'd0;
      end
      pend_v     <= 1'b0;
      pend_we    <= 1'b0;
      pend_pc    <= '0;
      pend_addr  <= '0;
      pend_data  <= '0;
      bus.pc_out     <= '0;
      bus.enable_out <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      if (commit_wr) begin
        regs[pend_addr] <= pend_data;
      end
      if (pend_v) begin
        bus.pc_out <= pend_pc;
      end
      bus.enable_out <= pend_v;
      pend_v <= bus.enable;
      if (bus.enable) begin
        pend_we   <= bus.we_in;
        pend_pc   <= bus.pc_in;
        pend_addr <= bus.wr_addr_in;
        pend_data <= bus.wr_data_in;
      end
    end
  end
endmodule

// File: tb/tb_stage8wb.sv
// tb/tb_stage8wb.sv - scoreboard bench for stage8wb with a behavioural register-file model
module tb_stage8wb;
  localparam int DW = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stage8wb_if #(.DATA_W(DW)) bus();
  stage8wb #(.DATA_W(DW), .NREGS(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  int m_regs [16];
  int m_cnt  [16];
  bit h_v, h_we;
  int h_pc, h_addr, h_data;
  int retire_q [$];
  bit mon_on = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_rd(int a);
    if (a == 0) return 0;
    if (h_v && h_we && h_addr == a) return h_data;
    return m_regs[a];
  endfunction

  function automatic int exp_busy(int a);
    if (a == 0 || m_cnt[a] == 0) return 0;
    if (h_v && h_we && h_addr == a && m_cnt[a] == 1) return 0;
    return 1;
  endfunction

  task automatic model_edge();
    int ca;
    int dec_addr;
    bit inc;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_regs[i] = 0;
        m_cnt[i]  = 0;
      end
      h_v = 0;
    end else begin
      ca  = int'(bus.claim_addr);
      inc = bus.claim && ca != 0 && m_cnt[ca] < 3;
      dec_addr = 0;
      if (h_v) begin
        retire_q.push_back(h_pc);
        if (h_we && h_addr != 0) begin
          m_regs[h_addr] = h_data;
          dec_addr = h_addr;
        end
      end
      if (!(inc && dec_addr == ca)) begin
        if (inc) m_cnt[ca]++;
        if (dec_addr != 0 && m_cnt[dec_addr] > 0) m_cnt[dec_addr]--;
      end
      h_v = bus.enable;
      if (bus.enable) begin
        h_we   = bus.we_in;
        h_pc   = int'(bus.pc_in);
        h_addr = int'(bus.wr_addr_in);
        h_data = int'(bus.wr_data_in);
      end
    end
  endtask

  task automatic step(bit en, int pc, bit we, int wa, int wd,
                      int ra, int rb, bit cl, int ca, bit r);
    rst            = r;
    bus.enable     = en;
    bus.pc_in      = pc[11:0];
    bus.we_in      = we;
    bus.wr_addr_in = wa[3:0];
    bus.wr_data_in = wd[DW-1:0];
    bus.rd_addr_a  = ra[3:0];
    bus.rd_addr_b  = rb[3:0];
    bus.claim      = cl;
    bus.claim_addr = ca[3:0];
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      chk("rd_data_a", bus.rd_data_a, exp_rd(int'(bus.rd_addr_a)));
      chk("rd_data_b", bus.rd_data_b, exp_rd(int'(bus.rd_addr_b)));
      chk("rd_busy_a", bus.rd_busy_a, exp_busy(int'(bus.rd_addr_a)));
      chk("rd_busy_b", bus.rd_busy_b, exp_busy(int'(bus.rd_addr_b)));
      chk("claim_ready", bus.claim_ready,
          (bus.claim_addr == 0 || m_cnt[bus.claim_addr] != 3) ? 1 : 0);
      if (bus.enable_out) begin
        if (retire_q.size() == 0) chk("spurious_retire", bus.enable_out, 0);
        else chk("retire_pc", bus.pc_out, retire_q.pop_front());
      end else if (retire_q.size() != 0) begin
        chk("retire_strobe", bus.enable_out, 1);
        void'(retire_q.pop_front());
      end
    end
  end

  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    mon_on = 1'b1;
    chk("reset_pc_out", bus.pc_out, 0);
    chk("reset_enable_out", bus.enable_out, 0);

    // single write/retire, bypass visible the cycle after capture
    step(1, 'h010, 1, 3, 'hABCDEF, 3, 0, 0, 0, 0);
    chk("bypass_r3", bus.rd_data_a, 'hABCDEF);
    step(0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
    chk("retire_010_pc", bus.pc_out, 'h010);
    chk("retire_010_en", bus.enable_out, 1);
    step(0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
    chk("retire_010_once", bus.enable_out, 0);
    chk("regs_r3", bus.rd_data_a, 'hABCDEF);

    // back-to-back results
    step(1, 'h020, 1, 1, 1, 1, 2, 0, 0, 0);
    step(1, 'h021, 1, 2, 2, 1, 2, 0, 0, 0);
    step(1, 'h022, 1, 1, 3, 1, 2, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    chk("final_r1", bus.rd_data_a, 3);
    chk("final_r2", bus.rd_data_b, 2);

    // scoreboard saturation on R4, then drain with a claim overlapping a commit
    repeat (3) step(0, 0, 0, 0, 0, 4, 0, 1, 4, 0);
    chk("r4_busy_sat", bus.rd_busy_a, 1);
    step(0, 0, 0, 0, 0, 4, 0, 1, 4, 0);
    step(1, 'h030, 1, 4, 'h44, 4, 0, 1, 4, 0);
    step(1, 'h031, 1, 4, 'h45, 4, 0, 1, 4, 0);
    step(1, 'h032, 1, 4, 'h46, 4, 0, 0, 0, 0);
    step(1, 'h033, 1, 4, 'h47, 4, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 4, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 4, 0, 0, 0, 0);
    chk("r4_idle_busy", bus.rd_busy_a, 0);

    // R0 is hardwired
    step(1, 'h040, 1, 0, 'hFFFFFF, 0, 0, 1, 0, 0);
    chk("r0_claim_ready", bus.claim_ready, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("r0_read", bus.rd_data_b, 0);
    chk("r0_busy", bus.rd_busy_b, 0);

    // underflow guard on R7
    step(1, 'h050, 1, 7, 'h777777, 7, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
    chk("r7_write", bus.rd_data_a, 'h777777);
    chk("r7_busy", bus.rd_busy_a, 0);

    // reset drops the held result
    step(1, 'h060, 1, 5, 'h555555, 5, 0, 0, 0, 0);
    step(1, 'h123, 1, 5, 'h121212, 5, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 5, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 5, 0, 0, 0, 1);
    chk("rst_pc_out", bus.pc_out, 0);
    chk("rst_enable_out", bus.enable_out, 0);
    chk("rst_r5", bus.rd_data_a, 0);
    step(0, 0, 0, 0, 0, 5, 0, 0, 0, 0);

    for (int n = 0; n < 500; n++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 4095)), $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 15)), int'($urandom & 32'hFFFFFF),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           $urandom_range(0, 2) == 0, int'($urandom_range(0, 15)),
           $urandom_range(0, 99) == 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("retire_queue_drained", retire_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
